// File: rtl/equ_pkg.sv
// Shared types, default sizes and the symbol-sequencing helper for the
// equalizer write-address generator.
package equ_pkg;

  localparam int unsigned N_SC_DEF      = 12;
  localparam int unsigned N_SYM_DEF     = 7;
  localparam int unsigned PILOT_SYM_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    WAIT_NEXT
  } equ_state_e;

  // Next data symbol after cur, stepping over the DMRS pilot symbol.
  function automatic int unsigned next_data_sym(input int unsigned cur, input int unsigned pilot);
    int unsigned n;
    n = cur + 1;
    if (n == pilot) n = n + 1;
    return n;
  endfunction

endpackage

// File: rtl/equ_sc_counter.sv
// Modulo-i_mod subcarrier counter with enable and synchronous clear.
// o_wrap flags the terminal count, so an enabled step from here returns to 0.
module equ_sc_counter #(
  parameter int unsigned W = 4
) (
  input  logic         i_clk_equ,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W:0]   i_mod,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);

  logic [W-1:0] r_cnt;
  logic         w_wrap;

  assign w_wrap = ({1'b0, r_cnt} == (i_mod - (W + 1)'(1)));
  assign o_cnt  = r_cnt;
  assign o_wrap = w_wrap;

  // Count enabled steps, wrapping at i_mod-1; clear wins over enable.
  always_ff @(posedge i_clk_equ or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/equ_wr_addr_gen.sv
// Write-address generator for the equalizer ping-pong symbol buffer.
// Walks the data symbols of a slot (skipping the pilot), alternating banks.
module equ_wr_addr_gen
  import equ_pkg::*;
#(
  parameter int unsigned N_SC      = N_SC_DEF,
  parameter int unsigned N_SYM     = N_SYM_DEF,
  parameter int unsigned PILOT_SYM = PILOT_SYM_DEF,
  localparam int unsigned SC_W     = $clog2(N_SC),
  localparam int unsigned SYM_W    = $clog2(N_SYM + 1)
) (
  input  logic             i_clk_equ,
  input  logic             i_rst_n,
  input  logic             i_sym_start,
  input  logic [SYM_W-1:0] i_symbol_num,
  input  logic [SC_W:0]    i_n_tones,
  input  logic             i_sample_valid,
  input  logic             i_abort,
  input  logic             i_clr_err,
  output logic             o_wr_en,
  output logic [SC_W:0]    o_wr_add,
  output logic             o_bank,
  output logic             o_sym_done,
  output logic [SYM_W-1:0] o_sym_idx,
  output logic             o_slot_done,
  output logic             o_err_seq
);

  localparam logic [SC_W:0]    TONES_MAX = (SC_W + 1)'(N_SC);
  localparam logic [SYM_W-1:0] FIRST_SYM = SYM_W'((PILOT_SYM == 1) ? 2 : 1);
  localparam logic [SYM_W-1:0] LAST_SYM  = SYM_W'((PILOT_SYM == N_SYM) ? N_SYM - 1 : N_SYM);
  localparam logic [SYM_W-1:0] PILOT     = SYM_W'(PILOT_SYM);

  equ_state_e       r_state, w_state_nxt;
  logic [SYM_W-1:0] r_cur_sym, w_cur_sym_nxt;
  logic [SYM_W-1:0] r_exp_sym, w_exp_sym_nxt;
  logic [SYM_W-1:0] r_sym_idx, w_sym_idx_nxt;
  logic [SC_W:0]    r_tones, w_tones_nxt;
  logic             r_bank, w_bank_nxt;
  logic             r_sym_done, w_sym_done_nxt;
  logic             r_slot_done, w_slot_done_nxt;
  logic             r_err_seq, w_err_set;
  logic             w_cnt_en, w_cnt_clr;
  logic [SC_W-1:0]  w_sc_cnt;
  logic             w_wrap;

  equ_sc_counter #(
    .W(SC_W)
  ) u_sc_counter (
    .i_clk_equ(i_clk_equ),
    .i_rst_n  (i_rst_n),
    .i_en     (w_cnt_en),
    .i_clr    (w_cnt_clr),
    .i_mod    (r_tones),
    .o_cnt    (w_sc_cnt),
    .o_wrap   (w_wrap)
  );

  // Next-state, counter control and done/error generation.
  always_comb begin
    w_state_nxt     = r_state;
    w_cur_sym_nxt   = r_cur_sym;
    w_exp_sym_nxt   = r_exp_sym;
    w_tones_nxt     = r_tones;
    w_bank_nxt      = r_bank;
    w_sym_done_nxt  = 1'b0;
    w_slot_done_nxt = 1'b0;
    w_sym_idx_nxt   = '0;
    w_err_set       = 1'b0;
    w_cnt_en        = 1'b0;
    w_cnt_clr       = 1'b0;
    if (i_abort) begin
      w_state_nxt = IDLE;
      w_bank_nxt  = 1'b0;
      w_cnt_clr   = 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_sym_start && (i_symbol_num == FIRST_SYM)) begin
            w_tones_nxt   = ((i_n_tones == '0) || (i_n_tones > TONES_MAX)) ? TONES_MAX : i_n_tones;
            w_cur_sym_nxt = i_symbol_num;
            w_bank_nxt    = 1'b0;
            w_cnt_clr     = 1'b1;
            w_state_nxt   = WRITE;
          end
        end
        WRITE: begin
          if (i_sym_start) begin
            // New symbol before this one filled: under-run.
            w_err_set   = 1'b1;
            w_cnt_clr   = 1'b1;
            w_state_nxt = IDLE;
          end else if (i_sample_valid) begin
            w_cnt_en = 1'b1;
            if (w_wrap) begin
              w_sym_done_nxt = 1'b1;
              w_sym_idx_nxt  = r_cur_sym;
              if (r_cur_sym == LAST_SYM) begin
                w_slot_done_nxt = 1'b1;
                w_state_nxt     = IDLE;
              end else begin
                w_bank_nxt    = ~r_bank;
                w_exp_sym_nxt = SYM_W'(next_data_sym(32'(r_cur_sym), PILOT_SYM));
                w_state_nxt   = WAIT_NEXT;
              end
            end
          end
        end
        WAIT_NEXT: begin
          if (i_sym_start) begin
            if (i_symbol_num == r_exp_sym) begin
              w_cur_sym_nxt = i_symbol_num;
              w_state_nxt   = WRITE;
            end else if (i_symbol_num != PILOT) begin
              w_err_set   = 1'b1;
              w_state_nxt = IDLE;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State and registered outputs; a new error outranks a clear request.
  always_ff @(posedge i_clk_equ or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_cur_sym   <= '0;
      r_exp_sym   <= '0;
      r_sym_idx   <= '0;
      r_tones     <= TONES_MAX;
      r_bank      <= 1'b0;
      r_sym_done  <= 1'b0;
      r_slot_done <= 1'b0;
      r_err_seq   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_sym   <= w_cur_sym_nxt;
      r_exp_sym   <= w_exp_sym_nxt;
      r_sym_idx   <= w_sym_idx_nxt;
      r_tones     <= w_tones_nxt;
      r_bank      <= w_bank_nxt;
      r_sym_done  <= w_sym_done_nxt;
      r_slot_done <= w_slot_done_nxt;
      if (w_err_set) begin
        r_err_seq <= 1'b1;
      end else if (i_clr_err) begin
        r_err_seq <= 1'b0;
      end
    end
  end

  assign o_wr_en     = (r_state == WRITE) && i_sample_valid;
  assign o_wr_add    = {r_bank, w_sc_cnt};
  assign o_bank      = r_bank;
  assign o_sym_done  = r_sym_done;
  assign o_sym_idx   = r_sym_idx;
  assign o_slot_done = r_slot_done;
  assign o_err_seq   = r_err_seq;

endmodule

// File: tb/tb_equ_wr_addr_gen.sv
// Directed bench for equ_wr_addr_gen (N_SC=12, N_SYM=7, PILOT_SYM=4).
module tb_equ_wr_addr_gen;

  logic       i_clk_equ = 1'b0;
  logic       i_rst_n;
  logic       i_sym_start;
  logic [2:0] i_symbol_num;
  logic [4:0] i_n_tones;
  logic       i_sample_valid;
  logic       i_abort;
  logic       i_clr_err;
  logic       o_wr_en;
  logic [4:0] o_wr_add;
  logic       o_bank;
  logic       o_sym_done;
  logic [2:0] o_sym_idx;
  logic       o_slot_done;
  logic       o_err_seq;

  int n_checks = 0;
  int n_fail   = 0;
  int n_wr     = 0;
  int n_done   = 0;

  always #5 i_clk_equ = ~i_clk_equ;

  equ_wr_addr_gen dut (
    .i_clk_equ     (i_clk_equ),
    .i_rst_n       (i_rst_n),
    .i_sym_start   (i_sym_start),
    .i_symbol_num  (i_symbol_num),
    .i_n_tones     (i_n_tones),
    .i_sample_valid(i_sample_valid),
    .i_abort       (i_abort),
    .i_clr_err     (i_clr_err),
    .o_wr_en       (o_wr_en),
    .o_wr_add      (o_wr_add),
    .o_bank        (o_bank),
    .o_sym_done    (o_sym_done),
    .o_sym_idx     (o_sym_idx),
    .o_slot_done   (o_slot_done),
    .o_err_seq     (o_err_seq)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Apply inputs just after an edge, then move to the mid-cycle sample point.
  task automatic drive(input bit s, input int n, input bit v);
    i_sym_start    = s;
    i_symbol_num   = 3'(n);
    i_sample_valid = v;
    #3;
  endtask

  task automatic tick();
    @(posedge i_clk_equ);
    #1;
  endtask

  // Start symbol num, feed n_valid samples (with idle gaps if gap), check the
  // addresses in the given bank and the done pulse that follows.
  task automatic write_sym(input int num, input int n_valid, input int bank, input bit gap,
                           input bit last);
    drive(1'b1, num, 1'b0);
    tick();
    for (int i = 0; i < n_valid; i++) begin
      drive(1'b0, 0, 1'b1);
      check("wr_en", int'(o_wr_en), 1);
      check("wr_add", int'(o_wr_add), bank * 16 + i);
      check("bank", int'(o_bank), bank);
      check("early_done", int'(o_sym_done), 0);
      if (o_wr_en) n_wr++;
      tick();
      if (gap && (i < n_valid - 1)) begin
        drive(1'b0, 0, 1'b0);
        check("gap_wr_en", int'(o_wr_en), 0);
        check("gap_hold", int'(o_wr_add), bank * 16 + i + 1);
        tick();
      end
    end
    drive(1'b0, 0, 1'b0);
    check("sym_done", int'(o_sym_done), 1);
    check("sym_idx", int'(o_sym_idx), num);
    check("slot_done", int'(o_slot_done), int'(last));
    if (o_sym_done) n_done++;
    tick();
    drive(1'b0, 0, 1'b0);
    check("done_1cyc", int'(o_sym_done), 0);
    check("slot_1cyc", int'(o_slot_done), 0);
    tick();
  endtask

  initial begin
    i_rst_n        = 1'b0;
    i_sym_start    = 1'b0;
    i_symbol_num   = '0;
    i_n_tones      = 5'd12;
    i_sample_valid = 1'b0;
    i_abort        = 1'b0;
    i_clr_err      = 1'b0;
    #2;
    check("rst_wr_en", int'(o_wr_en), 0);
    check("rst_wr_add", int'(o_wr_add), 0);
    check("rst_bank", int'(o_bank), 0);
    check("rst_sym_done", int'(o_sym_done), 0);
    check("rst_sym_idx", int'(o_sym_idx), 0);
    check("rst_slot_done", int'(o_slot_done), 0);
    check("rst_err", int'(o_err_seq), 0);
    #10 i_rst_n = 1'b1;
    tick();

    // Nominal slot, 12 tones, continuous valid.
    write_sym(1, 12, 0, 1'b0, 1'b0);
    write_sym(2, 12, 1, 1'b0, 1'b0);
    write_sym(3, 12, 0, 1'b0, 1'b0);
    write_sym(5, 12, 1, 1'b0, 1'b0);
    write_sym(6, 12, 0, 1'b0, 1'b0);
    write_sym(7, 12, 1, 1'b0, 1'b1);
    check("nom_writes", n_wr, 72);
    check("nom_dones", n_done, 6);
    check("nom_err", int'(o_err_seq), 0);

    // 3 tones with valid gaps, plus a pilot start that must be ignored.
    i_n_tones = 5'd3;
    write_sym(1, 3, 0, 1'b1, 1'b0);
    write_sym(2, 3, 1, 1'b1, 1'b0);
    write_sym(3, 3, 0, 1'b1, 1'b0);
    drive(1'b1, 4, 1'b0);
    tick();
    drive(1'b0, 0, 1'b1);
    check("pilot_no_wr", int'(o_wr_en), 0);
    check("pilot_err", int'(o_err_seq), 0);
    tick();
    write_sym(5, 3, 1, 1'b1, 1'b0);
    write_sym(6, 3, 0, 1'b1, 1'b0);
    write_sym(7, 3, 1, 1'b1, 1'b1);
    check("gap_err", int'(o_err_seq), 0);

    // Out-of-order symbol after symbol 2.
    write_sym(1, 3, 0, 1'b0, 1'b0);
    write_sym(2, 3, 1, 1'b0, 1'b0);
    drive(1'b1, 5, 1'b0);
    tick();
    i_clr_err = 1'b1;
    drive(1'b0, 0, 1'b0);
    check("order_err", int'(o_err_seq), 1);
    check("order_no_done", int'(o_sym_done), 0);
    tick();
    i_clr_err = 1'b0;
    drive(1'b0, 0, 1'b0);
    check("order_clr", int'(o_err_seq), 0);
    tick();
    drive(1'b1, 3, 1'b0);
    tick();
    drive(1'b0, 0, 1'b1);
    check("order_idle", int'(o_wr_en), 0);
    tick();

    // Under-run: new start at sc_cnt=7 of symbol 1.
    i_n_tones = 5'd12;
    drive(1'b1, 1, 1'b0);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 0, 1'b1);
      tick();
    end
    drive(1'b1, 2, 1'b0);
    check("ur_addr", int'(o_wr_add), 7);
    tick();
    drive(1'b0, 0, 1'b1);
    check("ur_err", int'(o_err_seq), 1);
    check("ur_no_done", int'(o_sym_done), 0);
    check("ur_idle", int'(o_wr_en), 0);
    tick();
    i_clr_err = 1'b1;
    drive(1'b0, 0, 1'b0);
    tick();
    i_clr_err = 1'b0;

    // Abort on what would be the completing sample of symbol 6.
    i_n_tones = 5'd3;
    write_sym(1, 3, 0, 1'b0, 1'b0);
    write_sym(2, 3, 1, 1'b0, 1'b0);
    write_sym(3, 3, 0, 1'b0, 1'b0);
    write_sym(5, 3, 1, 1'b0, 1'b0);
    drive(1'b1, 6, 1'b0);
    tick();
    drive(1'b0, 0, 1'b1);
    tick();
    drive(1'b0, 0, 1'b1);
    tick();
    i_abort = 1'b1;
    drive(1'b0, 0, 1'b1);
    tick();
    i_abort = 1'b0;
    drive(1'b0, 0, 1'b1);
    check("abort_no_done", int'(o_sym_done), 0);
    check("abort_no_slot", int'(o_slot_done), 0);
    check("abort_idle", int'(o_wr_en), 0);
    check("abort_addr", int'(o_wr_add), 0);
    check("abort_err", int'(o_err_seq), 0);
    tick();

    // Tone clamp: 0 -> 12.
    i_n_tones = 5'd0;
    write_sym(1, 12, 0, 1'b0, 1'b0);
    i_abort = 1'b1;
    drive(1'b0, 0, 1'b0);
    tick();
    i_abort = 1'b0;

    // Tone clamp: 15 -> 12, then async reset in the middle of symbol 2.
    i_n_tones = 5'd15;
    write_sym(1, 12, 0, 1'b0, 1'b0);
    drive(1'b1, 2, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 0, 1'b1);
      tick();
    end
    drive(1'b0, 0, 1'b1);
    check("pre_rst_addr", int'(o_wr_add), 21);
    check("pre_rst_bank", int'(o_bank), 1);
    i_rst_n = 1'b0;
    #1;
    check("arst_wr_en", int'(o_wr_en), 0);
    check("arst_wr_add", int'(o_wr_add), 0);
    check("arst_bank", int'(o_bank), 0);
    check("arst_done", int'(o_sym_done), 0);
    #2 i_rst_n = 1'b1;
    tick();
    i_n_tones = 5'd3;
    write_sym(1, 3, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/equ_wr_addr_gen.md
Name: equ_wr_addr_gen

Overview:
Parametrised write-address generator for the equalizer input symbol buffer in the NB-IoT uplink receive chain. It steps a subcarrier counter for each data symbol of a slot and skips the pilot symbol. It writes into a two-bank ping-pong buffer so the equalizer can read symbol k while symbol k+1 is written. It supports a run-time tone count, per-sample valid stalls, symbol-order checking, and done pulses to the equalizer controller.

Parameters:
N_SC, 12, maximum subcarriers (tones) per symbol; buffer depth per bank.
N_SYM, 7, SC-FDMA symbols per slot, numbered 1..N_SYM.
PILOT_SYM, 4, symbol index carrying DMRS; never written.
SC_W, $clog2(N_SC), subcarrier counter width (derived localparam).
SYM_W, $clog2(N_SYM+1), symbol-number width (derived localparam).

Ports:
i_clk_equ  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_sym_start  in  1  one-cycle pulse: a new symbol begins; qualifies i_symbol_num
i_symbol_num  in  SYM_W  symbol index 1..N_SYM, sampled only with i_sym_start
i_n_tones  in  SC_W+1  active tones for this slot, latched at slot start
i_sample_valid  in  1  one subcarrier sample present this cycle
i_abort  in  1  synchronous abort, highest priority after reset
i_clr_err  in  1  clears o_err_seq
o_wr_en  out  1  buffer write strobe
o_wr_add  out  SC_W+1  {bank, subcarrier index}
o_bank  out  1  bank currently being written
o_sym_done  out  1  one-cycle pulse: symbol completely written
o_sym_idx  out  SYM_W  index of the symbol just completed; valid with o_sym_done
o_slot_done  out  1  one-cycle pulse: last data symbol of slot written
o_err_seq  out  1  sticky sequence-error flag

Behaviour:
- Reset: state IDLE, sc_cnt=0, bank=0, cur_sym=0, tones=N_SC; all outputs 0.
- The design has three states: IDLE, WRITE, WAIT_NEXT.
- IDLE:
  - On i_sym_start with i_symbol_num==first data symbol (1, or 2 if PILOT_SYM==1): latch tones, cur_sym<=num, bank<=0, sc_cnt<=0, go to WRITE.
  - Any other i_sym_start is ignored; no error is raised.
- Tone latch: if i_n_tones==0 or i_n_tones>N_SC, tones<=N_SC; otherwise tones<=i_n_tones.
- WRITE:
  - o_wr_en = i_sample_valid (combinational).
  - o_wr_add = {bank, sc_cnt} (combinational from registers).
  - sc_cnt increments only on a valid sample; idle cycles stall.
  - On a valid sample with sc_cnt==tones-1: sc_cnt<=0, and on the next cycle o_sym_done=1 with o_sym_idx=cur_sym.
  - If cur_sym was the last data symbol (N_SYM, or N_SYM-1 if PILOT_SYM==N_SYM): o_slot_done=1 in the same cycle as o_sym_done, go to IDLE.
  - Otherwise: bank<=~bank, expected<=next data index, go to WAIT_NEXT.
  - i_sym_start during WRITE (symbol under-run): set o_err_seq, go to IDLE, no done pulses.
- WAIT_NEXT:
  - Samples are ignored and o_wr_en=0.
  - i_sym_start with num==expected: cur_sym<=num, go to WRITE.
  - i_sym_start with num==PILOT_SYM: ignored, no error.
  - Any other num: set o_err_seq, go to IDLE.
- Next data index: n=cur_sym+1; if n==PILOT_SYM then n+1.
- o_sym_done and o_slot_done are registered, one cycle each, never stretched.
- i_abort in any state: go to IDLE next cycle, bank=0, sc_cnt=0; pending done pulses are suppressed; o_err_seq is unchanged.
- o_err_seq: set takes priority over i_clr_err in the same cycle; cleared otherwise by i_clr_err or reset.
- tones==1: every valid sample completes a symbol; back-to-back symbols are legal when i_sym_start arrives the cycle after o_sym_done.
- Reset asserted mid-symbol: all state and outputs return to reset values immediately (asynchronous).

Decomposition:
- Package equ_pkg holds the state enum typedef (IDLE, WRITE, WAIT_NEXT), the defaults N_SC_DEF=12, N_SYM_DEF=7, PILOT_SYM_DEF=4, and a function next_data_sym(cur, pilot).
- One sub-module, equ_sc_counter: a modulo-tones counter with enable, clear, and a wrap flag, instanced once for sc_cnt.

Test Plan:
- Nominal slot, N_SC=12, tones=12, continuous valid: starts 1,2,3,5,6,7 -> 72 writes; addr 0..11 in bank0, 16..27 in bank1, alternating; 6 o_sym_done pulses with o_sym_idx 1,2,3,5,6,7; o_slot_done with symbol 7; o_err_seq=0.
- tones=3 with valid toggled 1-0-1-0: each symbol gives 3 writes at addr 0,1,2 (or 16,17,18); sc_cnt holds on valid=0; o_sym_done arrives the cycle after the 3rd valid.
- Pilot handling: after symbol 3 completes, pulse start with num=4 then num=5 -> the num=4 start is ignored, symbol 5 writes to the bank opposite symbol 3; o_err_seq=0.
- Order error: after symbol 2, start with num=5 -> o_err_seq=1, state IDLE, no o_sym_done; i_clr_err clears it next cycle.
- Under-run: i_sym_start at sc_cnt=7 of symbol 1 -> o_err_seq=1, IDLE, no done pulse. Separately, i_abort mid-symbol 6 -> IDLE, no o_slot_done.
- Config clamp plus async reset: i_n_tones=0 or 15 -> 12 writes per symbol. Asserting i_rst_n low mid-WRITE -> all outputs 0 in the same cycle; restart at symbol 1 in bank0.
